// File: rtl/bram_be_shadow_checker.sv
// -----------------------------------------------------------------------------
// bram_be_shadow_checker
//
// Equivalence checker for byte-enabled simple-dual-port BRAM mappings. It sits
// beside a gold behavioural RAM and a gate (techmapped) RAM that receive the
// same stimulus. A small shadow store follows NTRACK chosen addresses at
// byte-lane granularity. For each read it launches a check of {valid lanes,
// expected data, address} down a pipeline that matches the RAM read latency.
// The last stage compares both RAM outputs against the shadow, lane by lane.
//
// Optional feature macro: CHECKER_ASSERT_EN
//   defined   -> per-lane immediate assert and cover in the compare stage
//   undefined -> flags and counters only (output behaviour identical)
//
// Ports:
//   clk          sole clock
//   rst          synchronous active-high reset
//   track_addr   NTRACK*ABITS tracked addresses, slot k at [k*ABITS +: ABITS];
//                latched on every cycle with rst=1
//   we/be/wa/wd  write strobe, byte enables, write address, write data
//   re/ra        read strobe, read address
//   gold_rd      gold RAM read data
//   gate_rd      gate RAM read data
//   mismatch     one-cycle pulse per failing check
//   err          sticky error
//   err_count    saturating count of failing checks
//   err_addr     address of the first failing check
//   err_lanes    failing lanes of the first failing check
//   check_count  saturating count of checks with at least one valid lane
// -----------------------------------------------------------------------------
module bram_be_shadow_checker #(
  parameter int WDBITS    = 36,
  parameter int BYTEWIDTH = 9,
  parameter int NBYTES    = WDBITS / BYTEWIDTH,
  parameter int ABITS     = 10,
  parameter int NTRACK    = 4,
  parameter int RD_LAT    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NTRACK*ABITS-1:0] track_addr,
  input  logic                    we,
  input  logic [NBYTES-1:0]       be,
  input  logic [ABITS-1:0]        wa,
  input  logic [WDBITS-1:0]       wd,
  input  logic                    re,
  input  logic [ABITS-1:0]        ra,
  input  logic [WDBITS-1:0]       gold_rd,
  input  logic [WDBITS-1:0]       gate_rd,
  output logic                    mismatch,
  output logic                    err,
  output logic [15:0]             err_count,
  output logic [ABITS-1:0]        err_addr,
  output logic [NBYTES-1:0]       err_lanes,
  output logic [15:0]             check_count
);

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_ARMED  = 2'd1,
    ST_FAILED = 2'd2
  } state_t;

  // Shadow store
  logic [ABITS-1:0]  trk_q      [NTRACK];
  logic [ABITS-1:0]  trk_d      [NTRACK];
  logic [WDBITS-1:0] shd_data_q [NTRACK];
  logic [WDBITS-1:0] shd_data_d [NTRACK];
  logic [NBYTES-1:0] shd_wr_q   [NTRACK];
  logic [NBYTES-1:0] shd_wr_d   [NTRACK];

  // Read capture
  logic              cap_hit_s;
  logic [WDBITS-1:0] cap_exp_s;
  logic [NBYTES-1:0] cap_wr_s;
  logic [NBYTES-1:0] rdw_mask_s;
  logic [NBYTES-1:0] cap_valid_s;

  // Check pipeline: stage 0 is the capture register, stage RD_LAT feeds the
  // compare, so the expected data lines up with data returned RD_LAT later.
  logic [NBYTES-1:0] pipe_valid_q [RD_LAT+1];
  logic [NBYTES-1:0] pipe_valid_d [RD_LAT+1];
  logic [WDBITS-1:0] pipe_exp_q   [RD_LAT+1];
  logic [WDBITS-1:0] pipe_exp_d   [RD_LAT+1];
  logic [ABITS-1:0]  pipe_addr_q  [RD_LAT+1];
  logic [ABITS-1:0]  pipe_addr_d  [RD_LAT+1];

  // Compare stage
  logic [NBYTES-1:0] cmp_valid_s;
  logic [WDBITS-1:0] cmp_exp_s;
  logic [NBYTES-1:0] lane_fail_s;
  logic              any_fail_s;
  logic              any_check_s;

  // FSM and registered outputs
  state_t            state_q, state_d;
  logic              mismatch_q, mismatch_d;
  logic              err_q, err_d;
  logic [15:0]       err_count_q, err_count_d;
  logic [15:0]       check_count_q, check_count_d;
  logic [ABITS-1:0]  err_addr_q, err_addr_d;
  logic [NBYTES-1:0] err_lanes_q, err_lanes_d;

  // Shadow next state: latch tracked addresses during reset, merge enabled
  // write lanes into every matching slot (duplicates update identically).
  always_comb begin
    trk_d      = trk_q;
    shd_data_d = shd_data_q;
    shd_wr_d   = shd_wr_q;
    for (int k = 0; k < NTRACK; k++) begin
      if (rst) begin
        trk_d[k] = track_addr[k*ABITS +: ABITS];
      end else begin
        trk_d[k] = trk_q[k];
      end
      if (we && (wa == trk_q[k])) begin
        for (int i = 0; i < NBYTES; i++) begin
          if (be[i]) begin
            shd_data_d[k][i*BYTEWIDTH +: BYTEWIDTH] = wd[i*BYTEWIDTH +: BYTEWIDTH];
            shd_wr_d[k][i] = 1'b1;
          end else begin
            shd_data_d[k][i*BYTEWIDTH +: BYTEWIDTH] = shd_data_q[k][i*BYTEWIDTH +: BYTEWIDTH];
            shd_wr_d[k][i] = shd_wr_q[k][i];
          end
        end
      end else begin
        shd_data_d[k] = shd_data_q[k];
        shd_wr_d[k]   = shd_wr_q[k];
      end
    end
  end

  // Read capture: lowest matching slot supplies the pre-write shadow contents;
  // lanes being written in the same cycle are left unchecked.
  always_comb begin
    cap_hit_s = 1'b0;
    cap_exp_s = {WDBITS{1'b0}};
    cap_wr_s  = {NBYTES{1'b0}};
    for (int k = 0; k < NTRACK; k++) begin
      if (!cap_hit_s && (ra == trk_q[k])) begin
        cap_hit_s = 1'b1;
        cap_exp_s = shd_data_q[k];
        cap_wr_s  = shd_wr_q[k];
      end else begin
        cap_hit_s = cap_hit_s;
      end
    end
    if (we && (wa == ra)) begin
      rdw_mask_s = be;
    end else begin
      rdw_mask_s = {NBYTES{1'b0}};
    end
    if (re && cap_hit_s) begin
      cap_valid_s = cap_wr_s & ~rdw_mask_s;
    end else begin
      cap_valid_s = {NBYTES{1'b0}};
    end
  end

  // Pipeline next state: capture into stage 0, shift the rest.
  always_comb begin
    pipe_valid_d[0] = cap_valid_s;
    pipe_exp_d[0]   = cap_exp_s;
    pipe_addr_d[0]  = ra;
    for (int j = 1; j <= RD_LAT; j++) begin
      pipe_valid_d[j] = pipe_valid_q[j-1];
      pipe_exp_d[j]   = pipe_exp_q[j-1];
      pipe_addr_d[j]  = pipe_addr_q[j-1];
    end
  end

  // Per-lane compare: a valid lane fails if gold and gate disagree, or if the
  // gate disagrees with the shadow.
  always_comb begin
    cmp_valid_s = pipe_valid_q[RD_LAT];
    cmp_exp_s   = pipe_exp_q[RD_LAT];
    lane_fail_s = {NBYTES{1'b0}};
    for (int i = 0; i < NBYTES; i++) begin
      if (cmp_valid_s[i]) begin
        lane_fail_s[i] =
          (gold_rd[i*BYTEWIDTH +: BYTEWIDTH] != gate_rd[i*BYTEWIDTH +: BYTEWIDTH]) ||
          (gate_rd[i*BYTEWIDTH +: BYTEWIDTH] != cmp_exp_s[i*BYTEWIDTH +: BYTEWIDTH]);
      end else begin
        lane_fail_s[i] = 1'b0;
      end
    end
    any_fail_s  = |lane_fail_s;
    any_check_s = |cmp_valid_s;
  end

  // Check FSM next state, first-failure capture and saturating counters.
  always_comb begin
    state_d       = state_q;
    mismatch_d    = any_fail_s;
    err_d         = err_q;
    err_addr_d    = err_addr_q;
    err_lanes_d   = err_lanes_q;
    err_count_d   = err_count_q;
    check_count_d = check_count_q;

    case (state_q)
      ST_RESET, ST_ARMED: begin
        if (any_fail_s) begin
          state_d     = ST_FAILED;
          err_d       = 1'b1;
          err_addr_d  = pipe_addr_q[RD_LAT];
          err_lanes_d = lane_fail_s;
        end else begin
          state_d     = ST_ARMED;
        end
      end
      ST_FAILED: begin
        state_d = ST_FAILED;
        err_d   = 1'b1;
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase

    if (any_fail_s && (err_count_q != CNT_MAX)) begin
      err_count_d = err_count_q + 16'd1;
    end else begin
      err_count_d = err_count_q;
    end
    if (any_check_s && (check_count_q != CNT_MAX)) begin
      check_count_d = check_count_q + 16'd1;
    end else begin
      check_count_d = check_count_q;
    end
  end

  // Shadow registers; tracked addresses follow trk_d, which loads during rst.
  always_ff @(posedge clk) begin
    trk_q <= trk_d;
    if (rst) begin
      for (int k = 0; k < NTRACK; k++) begin
        shd_data_q[k] <= {WDBITS{1'b0}};
        shd_wr_q[k]   <= {NBYTES{1'b0}};
      end
    end else begin
      shd_data_q <= shd_data_d;
      shd_wr_q   <= shd_wr_d;
    end
  end

  // Check pipeline registers; reset drops all in-flight checks.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j <= RD_LAT; j++) begin
        pipe_valid_q[j] <= {NBYTES{1'b0}};
        pipe_exp_q[j]   <= {WDBITS{1'b0}};
        pipe_addr_q[j]  <= {ABITS{1'b0}};
      end
    end else begin
      pipe_valid_q <= pipe_valid_d;
      pipe_exp_q   <= pipe_exp_d;
      pipe_addr_q  <= pipe_addr_d;
    end
  end

  // FSM state and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RESET;
      mismatch_q    <= 1'b0;
      err_q         <= 1'b0;
      err_addr_q    <= {ABITS{1'b0}};
      err_lanes_q   <= {NBYTES{1'b0}};
      err_count_q   <= 16'd0;
      check_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      mismatch_q    <= mismatch_d;
      err_q         <= err_d;
      err_addr_q    <= err_addr_d;
      err_lanes_q   <= err_lanes_d;
      err_count_q   <= err_count_d;
      check_count_q <= check_count_d;
    end
  end

  assign mismatch    = mismatch_q;
  assign err         = err_q;
  assign err_count   = err_count_q;
  assign err_addr    = err_addr_q;
  assign err_lanes   = err_lanes_q;
  assign check_count = check_count_q;

`ifdef CHECKER_ASSERT_EN
  // Per-lane equivalence assertion and pass cover at the compare stage.
  always @(posedge clk) begin
    for (int i = 0; i < NBYTES; i++) begin
      if (!rst && cmp_valid_s[i]) begin
        assert (!lane_fail_s[i])
          else $error("lane %0d differs at addr %0h", i, pipe_addr_q[RD_LAT]);
      end else begin
      end
      cover (!rst && cmp_valid_s[i] && !lane_fail_s[i]);
    end
  end
`else
`endif

endmodule

// File: tb/tb_bram_be_shadow_checker.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for bram_be_shadow_checker. Three instances
// (RD_LAT = 1, 2, 3) see identical stimulus; the bench delays its own read
// data so each instance receives it RD_LAT cycles after its capture stage.
// -----------------------------------------------------------------------------
module tb_bram_be_shadow_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic [39:0] track_addr;
  logic        we, re;
  logic [3:0]  be;
  logic [9:0]  wa, ra;
  logic [35:0] wd;
  logic [35:0] gold_src, gate_src;
  logic [35:0] gold_dl [1:4];
  logic [35:0] gate_dl [1:4];

  logic [3:1]  mm;
  logic [3:1]  er;
  logic [15:0] ec [1:3];
  logic [15:0] cc [1:3];
  logic [9:0]  ea [1:3];
  logic [3:0]  el [1:3];

  int pulses [1:3] = '{0, 0, 0};
  int p0     [1:3];
  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;

  localparam logic [35:0] VAL_A = 36'hABCDE1234;
  localparam logic [35:0] VAL_B = 36'h0F0F0F0F0;

  always #5 clk = ~clk;

  // Read-data delay line standing in for the RAM latency
  always @(posedge clk) begin
    gold_dl[1] <= gold_src;
    gate_dl[1] <= gate_src;
    for (int j = 2; j <= 4; j++) begin
      gold_dl[j] <= gold_dl[j-1];
      gate_dl[j] <= gate_dl[j-1];
    end
  end

  // Count cycles with mismatch high, per instance
  always @(posedge clk) begin
    for (int l = 1; l <= 3; l++) pulses[l] <= pulses[l] + int'(mm[l]);
  end

  for (genvar L = 1; L <= 3; L++) begin : g_dut
    bram_be_shadow_checker #(.RD_LAT(L)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .track_addr (track_addr),
      .we         (we),
      .be         (be),
      .wa         (wa),
      .wd         (wd),
      .re         (re),
      .ra         (ra),
      .gold_rd    (gold_dl[L+1]),
      .gate_rd    (gate_dl[L+1]),
      .mismatch   (mm[L]),
      .err        (er[L]),
      .err_count  (ec[L]),
      .err_addr   (ea[L]),
      .err_lanes  (el[L]),
      .check_count(cc[L])
    );
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_write(input logic [9:0] a, input logic [35:0] d, input logic [3:0] b);
    we = 1'b1; wa = a; wd = d; be = b;
    step();
    we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int l = 1; l <= 3; l++) begin
      check($sformatf("%s_mm%0d", tag, l), 64'(mm[l]), 64'd0);
      check($sformatf("%s_err%0d", tag, l), 64'(er[l]), 64'd0);
      check($sformatf("%s_ec%0d", tag, l), 64'(ec[l]), 64'd0);
      check($sformatf("%s_cc%0d", tag, l), 64'(cc[l]), 64'd0);
      check($sformatf("%s_ea%0d", tag, l), 64'(ea[l]), 64'd0);
      check($sformatf("%s_el%0d", tag, l), 64'(el[l]), 64'd0);
    end
  endtask

  initial begin
    // slot3..slot0 = 0x020, 0x005, 0x005 (duplicate), 0x010
    track_addr = {10'h020, 10'h005, 10'h005, 10'h010};
    rst = 1'b1; we = 1'b0; re = 1'b0; be = 4'h0;
    wa = 10'h000; ra = 10'h000; wd = 36'h0;
    gold_src = 36'h0; gate_src = 36'h0;
    step(2);
    check_all_zero("reset");
    rst = 1'b0;

    // Full write then matching read
    do_write(10'h005, 36'h123456789, 4'b1111);
    re = 1'b1; ra = 10'h005; gold_src = 36'h123456789; gate_src = 36'h123456789;
    step();
    re = 1'b0;
    step(2);
    check("t1_cc_lat1", 64'(cc[1]), 64'd1);
    check("t1_mm_lat1", 64'(mm[1]), 64'd0);
    check("t1_err_lat1", 64'(er[1]), 64'd0);
    step(2);
    check("t1_cc_lat3", 64'(cc[3]), 64'd1);
    check("t1_err_lat3", 64'(er[3]), 64'd0);

    // Partial write: unwritten lane 1 corrupted is ignored
    do_reset();
    do_write(10'h005, 36'h0000000AB, 4'b0001);
    p0[1] = pulses[1];
    re = 1'b1; ra = 10'h005; gold_src = 36'h0000000AB; gate_src = 36'h0000002AB;
    step();
    re = 1'b0;
    step(4);
    check("t2_unwritten_pulses", 64'(pulses[1] - p0[1]), 64'd0);
    check("t2_unwritten_cc", 64'(cc[1]), 64'd1);
    check("t2_unwritten_err", 64'(er[1]), 64'd0);
    // Now corrupt written lane 0: pulse exactly after edge t+2
    re = 1'b1; gate_src = 36'h0000000AA;
    step();
    re = 1'b0;
    step();
    check("t2_mm_early", 64'(mm[1]), 64'd0);
    step();
    check("t2_mm_pulse", 64'(mm[1]), 64'd1);
    check("t2_err_lanes", 64'(el[1]), 64'h1);
    check("t2_err_addr", 64'(ea[1]), 64'h005);
    check("t2_err_count", 64'(ec[1]), 64'd1);
    step();
    check("t2_mm_end", 64'(mm[1]), 64'd0);
    check("t2_err_sticky", 64'(er[1]), 64'd1);
    check("t2_cc", 64'(cc[1]), 64'd2);

    // Read-during-write: only lanes 2-3 checked; then the merged value
    do_reset();
    do_write(10'h005, 36'h123456789, 4'b1111);
    p0[1] = pulses[1];
    we = 1'b1; wa = 10'h005; wd = 36'h0; be = 4'b0011;
    re = 1'b1; ra = 10'h005;
    gold_src = 36'h123456789 ^ 36'h00003FFFF; gate_src = 36'h123456789 ^ 36'h00003FFFF;
    step();
    we = 1'b0;
    gold_src = 36'h123440000; gate_src = 36'h123440000;
    step();
    ra = 10'h100; gold_src = 36'h0; gate_src = 36'h1;  // untracked read
    step();
    re = 1'b0;
    step(4);
    check("t3_cc", 64'(cc[1]), 64'd2);
    check("t3_err", 64'(er[1]), 64'd0);
    check("t3_pulses", 64'(pulses[1] - p0[1]), 64'd0);

    // Back-to-back reads, gate fault on the third read, all latencies
    do_reset();
    do_write(10'h010, VAL_A, 4'b1111);
    do_write(10'h005, VAL_B, 4'b1111);
    for (int l = 1; l <= 3; l++) p0[l] = pulses[l];
    for (int n = 0; n < 5; n++) begin
      re = 1'b1;
      ra = (n % 2 == 0) ? 10'h010 : 10'h005;
      gold_src = (n % 2 == 0) ? VAL_A : VAL_B;
      gate_src = (n == 2) ? (gold_src ^ 36'h000000001) : gold_src;
      step();
    end
    re = 1'b0;
    step(6);
    for (int l = 1; l <= 3; l++) begin
      check($sformatf("t4_pulses%0d", l), 64'(pulses[l] - p0[l]), 64'd1);
      check($sformatf("t4_ec%0d", l), 64'(ec[l]), 64'd1);
      check($sformatf("t4_err%0d", l), 64'(er[l]), 64'd1);
      check($sformatf("t4_cc%0d", l), 64'(cc[l]), 64'd5);
      check($sformatf("t4_ea%0d", l), 64'(ea[l]), 64'h010);
      check($sformatf("t4_el%0d", l), 64'(el[l]), 64'h1);
    end

    // Saturation: 70000 failing reads on lane 3 of a different address
    re = 1'b1; ra = 10'h005; gold_src = VAL_B; gate_src = VAL_B ^ 36'h008000000;
    for (int n = 0; n < 70000; n++) step();
    re = 1'b0;
    step(6);
    for (int l = 1; l <= 3; l++) begin
      check($sformatf("t5_ec%0d", l), 64'(ec[l]), 64'hFFFF);
      check($sformatf("t5_cc%0d", l), 64'(cc[l]), 64'hFFFF);
      check($sformatf("t5_ea%0d", l), 64'(ea[l]), 64'h010);
      check($sformatf("t5_el%0d", l), 64'(el[l]), 64'h1);
      check($sformatf("t5_err%0d", l), 64'(er[l]), 64'd1);
    end

    // Reset with two failing checks in flight
    for (int l = 1; l <= 3; l++) p0[l] = pulses[l];
    re = 1'b1; ra = 10'h005; gold_src = VAL_B; gate_src = VAL_B ^ 36'h000000001;
    step(2);
    re = 1'b0;
    do_reset();
    step(6);
    for (int l = 1; l <= 3; l++)
      check($sformatf("t6_inflight_pulses%0d", l), 64'(pulses[l] - p0[l]), 64'd0);
    check_all_zero("t6");
    // Old address no longer written: read is unchecked
    re = 1'b1; ra = 10'h005;
    step();
    re = 1'b0;
    step(6);
    for (int l = 1; l <= 3; l++) begin
      check($sformatf("t6_old_cc%0d", l), 64'(cc[l]), 64'd0);
      check($sformatf("t6_old_err%0d", l), 64'(er[l]), 64'd0);
      check($sformatf("t6_old_pulses%0d", l), 64'(pulses[l] - p0[l]), 64'd0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
